// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV64I controller
// and the datapath that it steers.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_R,
        CLS_I,
        CLS_BR
    } alu_cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    // Shared by register and immediate forms; alt picks SUB/SRA.
    function automatic logic [3:0] base_op(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Maps instruction class and {inst[30], funct3} to an ALU operation
// together with a legality flag for the register form.
module riscv_alu_decoder
    import riscv_mc_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [3:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    logic [2:0] f3;
    logic       alt;

    assign f3  = funct[2:0];
    assign alt = funct[3];

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        unique case (cls)
            CLS_R: begin
                if (alt && !(f3 == 3'b000 || f3 == 3'b101))
                    legal = 1'b0;
                else
                    alu_ctrl = base_op(f3, alt);
            end
            CLS_I: begin
                // inst[30] is immediate data except on the shift-right form
                alu_ctrl = base_op(f3, alt && (f3 == 3'b101));
            end
            CLS_BR: begin
                unique case (f3[2:1])
                    2'b00:   alu_ctrl = ALU_SUB;
                    2'b10:   alu_ctrl = ALU_SLT;
                    2'b11:   alu_ctrl = ALU_SLTU;
                    default: legal    = 1'b0;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV64I control unit: state machine, memory wait
// handshake with timeout, branch resolution and sticky traps.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT        = 16,
    parameter int unsigned TRAP_ON_ILLEGAL = 1,
    parameter int unsigned WAIT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [3:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_ctrl,
    output logic       instr_retired,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam bit TMO_EN   = (MAX_WAIT != 0);
    localparam bit TRAP_ILL = (TRAP_ON_ILLEGAL != 0);
    localparam int unsigned LAST_I = TMO_EN ? MAX_WAIT - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAST_I);

    state_t            state;
    state_t            state_nxt;
    state_t            dec_next;
    logic              dec_legal;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause_q;
    logic [1:0]        cause_nxt;
    logic              wait_st;
    logic              timeout;
    logic              take;
    alu_cls_t          alu_cls;
    logic [3:0]        alu_dec;
    logic              alu_legal;

    assign wait_st = (state == S_FETCH) || (state == S_MEM_RD) ||
                     (state == S_MEM_WR);

    // The access would exhaust its budget this cycle unless ready shows up
    assign timeout = TMO_EN && wait_st && !mem_ready &&
                     (wait_cnt == WAIT_LAST);

    assign take = zero ^ (funct[2] ^ funct[0]);

    always_comb begin
        alu_cls = CLS_ADD;
        unique case (state)
            S_EXEC_R: alu_cls = CLS_R;
            S_EXEC_I: alu_cls = CLS_I;
            S_BRANCH: alu_cls = CLS_BR;
            default:  alu_cls = CLS_ADD;
        endcase
    end

    riscv_alu_decoder u_alu_dec (
        .cls      (alu_cls),
        .funct    (funct),
        .alu_ctrl (alu_dec),
        .legal    (alu_legal)
    );

    always_comb begin
        dec_legal = 1'b1;
        dec_next  = S_FETCH;
        unique case (1'b1)
            opcode == OP_R:   dec_next = S_EXEC_R;
            opcode == OP_IMM: dec_next = S_EXEC_I;
            (opcode == OP_LOAD || opcode == OP_STORE) &&
            funct[2:0] == 3'b011:
                dec_next = S_MEM_ADDR;
            opcode == OP_BRANCH && funct[2:1] != 2'b01:
                dec_next = S_BRANCH;
            opcode == OP_JAL: dec_next = S_JAL;
            default:          dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = CAUSE_NONE;
        unique case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_nxt = dec_next;
                end else if (TRAP_ILL) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC_R: begin
                if (alu_legal) begin
                    state_nxt = S_ALU_WB;
                end else if (TRAP_ILL) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC_I: state_nxt = S_ALU_WB;
            S_ALU_WB: state_nxt = S_FETCH;
            S_MEM_ADDR: begin
                state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_nxt = S_MEM_WB;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_MEM_WB: state_nxt = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_BRANCH: state_nxt = S_FETCH;
            S_JAL:    state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Counter restarts on every state change, so entry to a wait state sees 0
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (wait_st && !mem_ready && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
            if (state_nxt == S_TRAP && state != S_TRAP)
                cause_q <= cause_nxt;
        end
    end

    always_comb begin
        pc_en         = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = M2R_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_B;
        pc_src        = PCSRC_ALU;
        alu_ctrl      = ALU_ADD;
        instr_retired = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a     = SRCA_OLDPC;
                    alu_src_b     = SRCB_IMM;
                    instr_retired = !dec_legal && !TRAP_ILL;
                end
                S_EXEC_R: begin
                    alu_src_a     = SRCA_A;
                    alu_src_b     = SRCB_B;
                    alu_ctrl      = alu_dec;
                    instr_retired = !alu_legal && !TRAP_ILL;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_A;
                    alu_src_b = SRCB_IMM;
                    alu_ctrl  = alu_dec;
                end
                S_ALU_WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = M2R_ALUOUT;
                    instr_retired = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = SRCA_A;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = M2R_MDR;
                    instr_retired = 1'b1;
                end
                S_MEM_WR: begin
                    i_or_d        = 1'b1;
                    mem_write     = 1'b1;
                    instr_retired = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a     = SRCA_A;
                    alu_src_b     = SRCB_B;
                    alu_ctrl      = alu_dec;
                    pc_en         = take;
                    pc_src        = PCSRC_ALUOUT;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    pc_en         = 1'b1;
                    pc_src        = PCSRC_ALUOUT;
                    reg_write     = 1'b1;
                    mem_to_reg    = M2R_PC;
                    instr_retired = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    assign trap       = !rst && (state == S_TRAP);
    assign trap_cause = rst ? CAUSE_NONE : cause_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: one trapping instance and
// one that retires illegal instructions, driven side by side.
module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [3:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en_a, i_or_d_a, mem_read_a, mem_write_a, ir_write_a;
    logic [1:0] mem_to_reg_a, alu_src_a_a, alu_src_b_a, pc_src_a;
    logic       reg_write_a, instr_retired_a, trap_a;
    logic [3:0] alu_ctrl_a;
    logic [1:0] trap_cause_a;

    logic       pc_en_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b;
    logic [1:0] mem_to_reg_b, alu_src_a_b, alu_src_b_b, pc_src_b;
    logic       reg_write_b, instr_retired_b, trap_b;
    logic [3:0] alu_ctrl_b;
    logic [1:0] trap_cause_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riscv_mc_controller #(
        .MAX_WAIT(16), .TRAP_ON_ILLEGAL(1), .WAIT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en_a), .i_or_d(i_or_d_a), .mem_read(mem_read_a),
        .mem_write(mem_write_a), .ir_write(ir_write_a),
        .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a),
        .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
        .pc_src(pc_src_a), .alu_ctrl(alu_ctrl_a),
        .instr_retired(instr_retired_a), .trap(trap_a),
        .trap_cause(trap_cause_a)
    );

    riscv_mc_controller #(
        .MAX_WAIT(16), .TRAP_ON_ILLEGAL(0), .WAIT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en_b), .i_or_d(i_or_d_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .ir_write(ir_write_b),
        .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
        .pc_src(pc_src_b), .alu_ctrl(alu_ctrl_b),
        .instr_retired(instr_retired_b), .trap(trap_b),
        .trap_cause(trap_cause_b)
    );

    wire [21:0] obs_a = {pc_en_a, i_or_d_a, mem_read_a, mem_write_a,
                         ir_write_a, mem_to_reg_a, reg_write_a,
                         alu_src_a_a, alu_src_b_a, pc_src_a, alu_ctrl_a,
                         instr_retired_a, trap_a, trap_cause_a};
    wire [21:0] obs_b = {pc_en_b, i_or_d_b, mem_read_b, mem_write_b,
                         ir_write_b, mem_to_reg_b, reg_write_b,
                         alu_src_a_b, alu_src_b_b, pc_src_b, alu_ctrl_b,
                         instr_retired_b, trap_b, trap_cause_b};

    // Bit positions of the packed observation word
    localparam logic [21:0] PE      = 22'h200000;
    localparam logic [21:0] IOD     = 22'h100000;
    localparam logic [21:0] MR      = 22'h080000;
    localparam logic [21:0] MW      = 22'h040000;
    localparam logic [21:0] IRW     = 22'h020000;
    localparam logic [21:0] M2R_PC  = 22'h010000;
    localparam logic [21:0] M2R_MDR = 22'h008000;
    localparam logic [21:0] RW      = 22'h004000;
    localparam logic [21:0] SA_A    = 22'h002000;
    localparam logic [21:0] SA_OLD  = 22'h001000;
    localparam logic [21:0] SB_IMM  = 22'h000800;
    localparam logic [21:0] SB_FOUR = 22'h000400;
    localparam logic [21:0] PS_OUT  = 22'h000100;
    localparam logic [21:0] RET     = 22'h000008;
    localparam logic [21:0] TR      = 22'h000004;
    localparam logic [21:0] CA_ILL  = 22'h000001;
    localparam logic [21:0] CA_BUS  = 22'h000002;

    localparam logic [21:0] V_OFF    = 22'h000000;
    localparam logic [21:0] V_F_RDY  = PE | MR | IRW | SB_FOUR;
    localparam logic [21:0] V_F_WAIT = MR | SB_FOUR;
    localparam logic [21:0] V_DEC    = SA_OLD | SB_IMM;
    localparam logic [21:0] V_EXR    = SA_A;
    localparam logic [21:0] V_EXI    = SA_A | SB_IMM;
    localparam logic [21:0] V_WB     = RW | RET;
    localparam logic [21:0] V_MADDR  = SA_A | SB_IMM;
    localparam logic [21:0] V_MRD    = IOD | MR;
    localparam logic [21:0] V_MWB    = RW | M2R_MDR | RET;
    localparam logic [21:0] V_MWR    = IOD | MW;
    localparam logic [21:0] V_BR     = SA_A | PS_OUT | RET;
    localparam logic [21:0] V_JAL    = PE | PS_OUT | RW | M2R_PC | RET;
    localparam logic [21:0] V_T_ILL  = TR | CA_ILL;
    localparam logic [21:0] V_T_BUS  = TR | CA_BUS;

    function automatic logic [21:0] ac(input logic [3:0] c);
        return {14'b0, c, 4'b0};
    endfunction

    task automatic cyc2(input string tag,
                        input logic [21:0] ea,
                        input logic [21:0] eb);
        @(negedge clk);
        vectors++;
        assert (obs_a === ea) else begin
            miscompares++;
            $error("FAIL %s trap_inst: got %06h expected %06h",
                   tag, obs_a, ea);
        end
        vectors++;
        assert (obs_b === eb) else begin
            miscompares++;
            $error("FAIL %s nop_inst: got %06h expected %06h",
                   tag, obs_b, eb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [21:0] e);
        cyc2(tag, e, e);
    endtask

    task automatic set_ins(input logic [6:0] op, input logic [3:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        set_ins(7'b0000000, 4'b0000);
        cyc("reset0", V_OFF);
        cyc("reset1", V_OFF);
        rst = 1'b0;

        set_ins(7'b0110011, 4'b0000);
        cyc("add_fetch", V_F_RDY);
        cyc("add_decode", V_DEC);
        cyc("add_exec", V_EXR | ac(4'b0000));
        cyc("add_wb", V_WB);

        set_ins(7'b0110011, 4'b1000);
        cyc("sub_fetch", V_F_RDY);
        cyc("sub_decode", V_DEC);
        cyc("sub_exec", V_EXR | ac(4'b0001));
        cyc("sub_wb", V_WB);

        set_ins(7'b0010011, 4'b1101);
        cyc("srai_fetch", V_F_RDY);
        cyc("srai_decode", V_DEC);
        cyc("srai_exec", V_EXI | ac(4'b0111));
        cyc("srai_wb", V_WB);

        set_ins(7'b0010011, 4'b1000);
        cyc("addi_fetch", V_F_RDY);
        cyc("addi_decode", V_DEC);
        cyc("addi_exec", V_EXI | ac(4'b0000));
        cyc("addi_wb", V_WB);

        set_ins(7'b0000011, 4'b0011);
        cyc("ld_fetch", V_F_RDY);
        cyc("ld_decode", V_DEC);
        cyc("ld_addr", V_MADDR);
        mem_ready = 1'b0;
        cyc("ld_wait1", V_MRD);
        cyc("ld_wait2", V_MRD);
        cyc("ld_wait3", V_MRD);
        mem_ready = 1'b1;
        cyc("ld_rd", V_MRD);
        cyc("ld_wb", V_MWB);

        set_ins(7'b0100011, 4'b0011);
        cyc("sd_fetch", V_F_RDY);
        cyc("sd_decode", V_DEC);
        cyc("sd_addr", V_MADDR);
        mem_ready = 1'b0;
        cyc("sd_wait", V_MWR);
        mem_ready = 1'b1;
        cyc("sd_wr", V_MWR | RET);

        set_ins(7'b1100011, 4'b0100);
        zero = 1'b0;
        cyc("blt_fetch", V_F_RDY);
        cyc("blt_decode", V_DEC);
        cyc("blt_taken", V_BR | PE | ac(4'b1000));

        set_ins(7'b1100011, 4'b0101);
        cyc("bge_fetch", V_F_RDY);
        cyc("bge_decode", V_DEC);
        cyc("bge_not", V_BR | ac(4'b1000));

        set_ins(7'b1100011, 4'b0000);
        zero = 1'b1;
        cyc("beq_fetch", V_F_RDY);
        cyc("beq_decode", V_DEC);
        cyc("beq_taken", V_BR | PE | ac(4'b0001));

        set_ins(7'b1100011, 4'b0111);
        zero = 1'b0;
        cyc("bgeu_fetch", V_F_RDY);
        cyc("bgeu_decode", V_DEC);
        cyc("bgeu_not", V_BR | ac(4'b1001));

        set_ins(7'b1101111, 4'b0000);
        cyc("jal_fetch", V_F_RDY);
        cyc("jal_decode", V_DEC);
        cyc("jal_exec", V_JAL);

        set_ins(7'b1111111, 4'b0000);
        cyc("ill_fetch", V_F_RDY);
        cyc2("ill_decode", V_DEC, V_DEC | RET);
        set_ins(7'b0110011, 4'b1111);
        cyc2("ill_trap0", V_T_ILL, V_F_RDY);
        cyc2("ill_trap1", V_T_ILL, V_DEC);
        cyc2("ill_trap2", V_T_ILL, V_EXR | RET);
        cyc2("ill_trap3", V_T_ILL, V_F_RDY);
        rst = 1'b1;
        cyc("rst_in_trap", V_OFF);
        rst = 1'b0;

        cyc("illr_fetch", V_F_RDY);
        cyc("illr_decode", V_DEC);
        cyc2("illr_exec", V_EXR, V_EXR | RET);
        cyc2("illr_after", V_T_ILL, V_F_RDY);
        rst = 1'b1;
        cyc("rst_illr", V_OFF);
        rst = 1'b0;

        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            cyc("tmo_wait", V_F_WAIT);
        cyc("tmo_trap0", V_T_BUS);
        mem_ready = 1'b1;
        cyc("tmo_trap1", V_T_BUS);
        rst = 1'b1;
        cyc("rst_tmo", V_OFF);
        rst = 1'b0;

        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            cyc("mid_wait", V_F_WAIT);
        rst = 1'b1;
        cyc("rst_mid", V_OFF);
        rst = 1'b0;
        for (int i = 0; i < 15; i++)
            cyc("post_rst_wait", V_F_WAIT);
        mem_ready = 1'b1;
        set_ins(7'b1101111, 4'b0000);
        cyc("ready_wins", V_F_RDY);
        cyc("late_decode", V_DEC);
        cyc("late_jal", V_JAL);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
